// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares one single-port memory between three requesters: a CPU data port,
//   a CPU instruction-fetch port and a display port that reads fixed-length
//   bursts. In IDLE a single grant is chosen combinationally each cycle with
//   priority data > fetch > display. A display grant starts a burst of
//   BURST_LEN consecutive reads from a latched base address. The burst owns
//   the memory until its last beat, even if the display drops its request.
//   Read data returns one cycle after the grant and is flagged by the
//   winner's rvalid.
//
// Optional feature (compile-time macro ARB_STARVE_EN):
//   When defined, a 4-bit wait counter tracks how long the display has been
//   requesting in IDLE without a grant. Once it reaches STARVE_MAX the
//   display takes top priority. When undefined, the display is strictly
//   lowest priority and may starve.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   d_req/d_we/d_addr/d_wdata  data port request (read or write)
//   d_gnt, d_rvalid          data grant, data read-return strobe
//   f_req/f_addr             fetch port read request
//   f_gnt, f_rvalid          fetch grant, fetch read-return strobe
//   v_req/v_addr             display burst request, burst base address
//   v_gnt, v_rvalid          display grant (every beat), beat read-return strobe
//   rdata                    read data (direct from mem_rdata)
//   cpu_stall                data or fetch port is requesting but not granted
//   mem_en/mem_we/mem_addr/mem_wdata  memory command for the current cycle
//   mem_rdata                memory read data, valid one cycle after a read
//   dbg_state                current FSM state (0 = IDLE, 1 = VBURST)
//
// Handshake: a requester holds req high; a request is accepted in any cycle
// in which its gnt is high (gnt is combinational in the same cycle). Each
// accepted read produces exactly one rvalid pulse, in the following cycle.
// Writes produce no rvalid.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 18,
    parameter int BURST_LEN  = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    // data port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    // fetch port
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    // display port
    input  logic              v_req,
    input  logic [ADDR_W-1:0] v_addr,
    output logic              v_gnt,
    output logic              v_rvalid,
    // shared outputs
    output logic [DATA_W-1:0] rdata,
    output logic              cpu_stall,
    // memory side
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    // debug
    output logic [0:0]        dbg_state
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] VBURST = 1'b1;

    // Beat 0 is issued from IDLE, so the counter holds the index of the beat
    // being issued while in VBURST.
    localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);

    logic [0:0]        state;
    logic [3:0]        beat_cnt;
    logic [ADDR_W-1:0] v_base;

    // Internal (ungated) winners; these feed the flops. The port-level
    // grants are additionally forced low while reset is held.
    logic              d_win;
    logic              f_win;
    logic              v_win;
    logic              starve;

    logic              mem_en_c;
    logic              mem_we_c;
    logic [ADDR_W-1:0] mem_addr_c;
    logic [DATA_W-1:0] mem_wdata_c;

    logic              d_rv_q;
    logic              f_rv_q;
    logic              v_rv_q;

    // -------------------------------------------------------------------------
    // Display starvation guard
    // -------------------------------------------------------------------------
`ifdef ARB_STARVE_EN
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;

    assign starve = (starve_cnt == STARVE_LIM);

    // Counts IDLE cycles in which the display waits. Every VBURST cycle is a
    // display grant, so the clear term also covers the whole burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 4'd0;
        end else if (!v_req || v_win) begin
            starve_cnt <= 4'd0;
        end else if (state == IDLE && starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`else
    assign starve = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    always_comb begin
        d_win = 1'b0;
        f_win = 1'b0;
        v_win = 1'b0;
        if (state == VBURST) begin
            v_win = 1'b1;
        end else if (starve && v_req) begin
            v_win = 1'b1;
        end else if (d_req) begin
            d_win = 1'b1;
        end else if (f_req) begin
            f_win = 1'b1;
        end else if (v_req) begin
            v_win = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Memory command mux
    // -------------------------------------------------------------------------
    always_comb begin
        mem_en_c    = d_win | f_win | v_win;
        mem_we_c    = d_win & d_we;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        if (d_win) begin
            mem_addr_c  = d_addr;
            mem_wdata_c = d_wdata;
        end else if (f_win) begin
            mem_addr_c  = f_addr;
        end else if (v_win) begin
            // Beat 0 comes straight from the port; later beats use the
            // latched base so v_addr changes mid-burst are ignored. The add
            // wraps naturally at the top of the address space.
            if (state == IDLE) begin
                mem_addr_c = v_addr;
            end else begin
                mem_addr_c = v_base + ADDR_W'(beat_cnt);
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM, burst tracking and read-return strobes
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            beat_cnt <= 4'd0;
            v_base   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (v_win) begin
                        state    <= VBURST;
                        beat_cnt <= 4'd1;
                        v_base   <= v_addr;
                    end
                end
                VBURST: begin
                    if (beat_cnt == LAST_BEAT) begin
                        state    <= IDLE;
                        beat_cnt <= 4'd0;
                    end else begin
                        beat_cnt <= beat_cnt + 4'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    beat_cnt <= 4'd0;
                end
            endcase
        end
    end

    // Reset clears these, so beats issued before a reset never return a strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_rv_q <= 1'b0;
            f_rv_q <= 1'b0;
            v_rv_q <= 1'b0;
        end else begin
            d_rv_q <= d_win & ~d_we;
            f_rv_q <= f_win;
            v_rv_q <= v_win;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. Combinational command outputs are forced to zero while reset
    // is held so that the whole memory-facing interface is quiet immediately.
    // -------------------------------------------------------------------------
    assign d_gnt     = d_win & rst_n;
    assign f_gnt     = f_win & rst_n;
    assign v_gnt     = v_win & rst_n;

    assign mem_en    = mem_en_c & rst_n;
    assign mem_we    = mem_we_c & rst_n;
    assign mem_addr  = rst_n ? mem_addr_c  : '0;
    assign mem_wdata = rst_n ? mem_wdata_c : '0;

    assign d_rvalid  = d_rv_q;
    assign f_rvalid  = f_rv_q;
    assign v_rvalid  = v_rv_q;

    assign rdata     = mem_rdata;
    assign cpu_stall = (d_req & ~d_gnt) | (f_req & ~f_gnt);
    assign dbg_state = state;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 16, address width; DATA_W, default 18, data word width; BURST_LEN, default 4, display burst length in beats (2..15); STARVE_MAX, default 8, display wait limit in cycles (1..15).
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset: clk input 1 rising-edge clock; rst_n input 1 reset, active-low.
REQ-003 Data port: d_req in 1; d_we in 1; d_addr in ADDR_W; d_wdata in DATA_W; d_gnt out 1; d_rvalid out 1.
REQ-004 Fetch port: f_req in 1; f_addr in ADDR_W; f_gnt out 1; f_rvalid out 1.
REQ-005 Display port: v_req in 1; v_addr in ADDR_W (burst base); v_gnt out 1; v_rvalid out 1.
REQ-006 Shared outputs: rdata out DATA_W, which SHALL equal mem_rdata; cpu_stall out 1.
REQ-007 Memory side: mem_en out 1; mem_we out 1; mem_addr out ADDR_W; mem_wdata out DATA_W; mem_rdata in DATA_W, valid one cycle after mem_en with mem_we=0.

Function
REQ-008 States SHALL be IDLE and VBURST.
REQ-009 In IDLE, at most one grant SHALL assert per cycle, combinationally, with priority data > fetch > display.
REQ-010 A granted cycle SHALL drive mem_en=1, with mem_addr/mem_we/mem_wdata taken from the winner; for fetch and display, mem_we=0.
REQ-011 With no grant, mem_en=0 and mem_we=0.
REQ-012 For a granted read, the winner's rvalid SHALL assert for exactly one cycle, on the cycle after the grant.
REQ-013 A data write (d_we=1) SHALL NOT assert d_rvalid.
REQ-014 A display grant in IDLE SHALL issue beat 0 at v_addr and move the block to VBURST.
REQ-015 In VBURST, beat k SHALL go to v_addr_latched+k (mod 2^ADDR_W, so it wraps at 0xFFFF→0x0000), with v_gnt=1 every cycle and no data or fetch grants.
REQ-016 After beat BURST_LEN-1 is issued, the block SHALL return to IDLE on the next edge.
REQ-017 A started burst SHALL complete even if v_req deasserts.
REQ-018 v_addr SHALL be latched at burst start; later changes to v_addr SHALL be ignored.
REQ-019 cpu_stall SHALL equal (d_req & ~d_gnt) | (f_req & ~f_gnt).
REQ-020 Simultaneous d_req and f_req SHALL grant data and stall fetch; fetch is granted on the first cycle d_req is low.

Reset
REQ-021 While rst_n=0, the following SHALL be cleared regardless of clk: state=IDLE; beat counter=0; starvation counter=0; all gnt and rvalid outputs=0; mem_en=0; mem_we=0; mem_addr=0; mem_wdata=0.
REQ-022 Reset during a burst SHALL abort it; no rvalid SHALL assert after reset release for beats issued before reset.
REQ-023 After rst_n rises, the first grant SHALL be possible on the first clk edge.

Configuration
REQ-024 Macro ARB_STARVE_EN SHALL control the display starvation guard.
REQ-025 With ARB_STARVE_EN defined: a 4-bit counter SHALL increment each IDLE cycle with v_req=1 and v_gnt=0, saturate at STARVE_MAX, and clear on a display grant or when v_req=0.
REQ-026 With ARB_STARVE_EN defined: when the counter equals STARVE_MAX, display SHALL have top priority in IDLE.
REQ-027 Without ARB_STARVE_EN: no counter SHALL exist, and display SHALL stay strictly lowest priority (starvation permitted).

Verification
REQ-028 Fetch read: f_req=1, f_addr=0x0010, mem returns 0x2A5A5 -> f_gnt in cycle 0, f_rvalid=1 and rdata=0x2A5A5 in cycle 1, cpu_stall=0.
REQ-029 Contention: d_req=1 (write 0x00FF to 0x0100) together with f_req=1 -> d_gnt=1, mem_we=1, f_gnt=0, cpu_stall=1, no d_rvalid; next cycle with d_req=0 -> f_gnt=1.
REQ-030 Burst wrap: v_req=1, v_addr=0xFFFE, BURST_LEN=4 -> mem_addr sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001; v_rvalid on 4 consecutive cycles; f_req during the burst stalled throughout; v_req dropped after beat 1 still gives 4 beats.
REQ-031 Starvation (ARB_STARVE_EN, STARVE_MAX=8): f_req and v_req held high -> fetch granted cycles 0..7, v_gnt in cycle 8; without the macro, v_gnt never asserts.
REQ-032 Reset mid-burst: rst_n=0 at beat 2 -> all outputs 0 immediately; after release, IDLE, with no v_rvalid for the aborted beats.
